mips150_io_ctrl: RTL and testbench

//   Memory-mapped IO controller for the MIPS150 pipeline: services X-stage loads/stores

---
 rtl/mips150_io_pkg.sv | 17 +
 rtl/mips150_io_rx_buf.sv | 74 +++++++
 rtl/mips150_io_ctrl.sv | 107 ++++++++++
 tb/tb_mips150_io_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips150_io_pkg.sv
// Shared constants for the MIPS150 memory-mapped IO controller.
// Register offsets are word indices taken from addr_x[7:2].
package mips150_io_pkg;

  localparam logic [3:0] IO_TOP_NIBBLE = 4'h8;

  localparam logic [5:0] IO_STATUS  = 6'h00;  // byte offset 0x00
  localparam logic [5:0] IO_RX_DATA = 6'h01;  // byte offset 0x04
  localparam logic [5:0] IO_TX_DATA = 6'h02;  // byte offset 0x08
  localparam logic [5:0] IO_CYCLES  = 6'h04;  // byte offset 0x10
  localparam logic [5:0] IO_INSTRS  = 6'h05;  // byte offset 0x14
  localparam logic [5:0] IO_CNT_RST = 6'h06;  // byte offset 0x18

  localparam int STATUS_TX_FREE  = 0;
  localparam int STATUS_RX_AVAIL = 1;

endpackage

// File: rtl/mips150_io_rx_buf.sv
// UART receive buffer: a DEPTH-entry circular FIFO when MIPS150_IO_RX_FIFO_EN is
// defined, otherwise a single holding register. Push/pop are ignored when full/empty.
module mips150_io_rx_buf #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] pushData,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

`ifdef MIPS150_IO_RX_FIFO_EN
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW:0]   count;
  logic [7:0]    mem [DEPTH];
  logic          pushOk;
  logic          popOk;

  assign full   = (count == (PW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign pushOk = push && !full;
  assign popOk  = pop && !empty;
  assign head   = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= pushData;
  end
`else
  logic       holdValid;
  logic [7:0] holdData;

  assign full  = holdValid;
  assign empty = !holdValid;
  assign head  = holdData;

  // Push needs an empty register and pop a full one, so they never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      holdValid <= 1'b0;
      holdData  <= '0;
    end else if (push && !holdValid) begin
      holdValid <= 1'b1;
      holdData  <= pushData;
    end else if (pop && holdValid) begin
      holdValid <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/mips150_io_ctrl.sv
// MIPS150 memory-mapped IO controller: UART RX/TX, cycle and instruction counters.
// RX buffering depth is selected by MIPS150_IO_RX_FIFO_EN (undefined: single entry).
module mips150_io_ctrl
  import mips150_io_pkg::*;
#(
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_x,
  input  logic [31:0] wdata_x,
  input  logic [3:0]  store_mask_io,
  input  logic        load_io_x,
  input  logic        instr_valid,
  output logic [31:0] rdata_m,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  // Handshakes: a byte moves on a clock edge where valid && ready are both high;
  // the sender keeps data stable while valid is high and ready never depends on valid.

  logic        hit;
  logic [5:0]  sel;
  logic        isLoad;
  logic        isStore;
  logic        rxFull;
  logic        rxEmpty;
  logic [7:0]  rxHead;
  logic        rxPush;
  logic        rxPop;
  logic [31:0] cycles;
  logic [31:0] instrs;
  logic [31:0] rdNext;
  logic        unusedBits;

  assign hit     = (addr_x[31:28] == IO_TOP_NIBBLE);
  assign sel     = addr_x[7:2];
  assign isLoad  = load_io_x && hit;
  assign isStore = (|store_mask_io) && hit;

  assign unusedBits = ^{addr_x[27:8], addr_x[1:0], wdata_x[31:8]};

  assign uart_rx_ready = !rxFull;
  assign rxPush        = uart_rx_valid && !rxFull;
  assign rxPop         = isLoad && (sel == IO_RX_DATA) && !rxEmpty;

  mips150_io_rx_buf #(
    .DEPTH(RX_FIFO_DEPTH)
  ) rxBuf (
    .clk     (clk),
    .rst     (rst),
    .push    (rxPush),
    .pop     (rxPop),
    .pushData(uart_rx_data),
    .full    (rxFull),
    .empty   (rxEmpty),
    .head    (rxHead)
  );

  always_comb begin
    rdNext = '0;
    case (sel)
      IO_STATUS: begin
        rdNext[STATUS_RX_AVAIL] = !rxEmpty;
        rdNext[STATUS_TX_FREE]  = !uart_tx_valid;
      end
      IO_RX_DATA: if (!rxEmpty) rdNext = {24'b0, rxHead};
      IO_CYCLES:  rdNext = cycles;
      IO_INSTRS:  rdNext = instrs;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_m <= '0;
    else if (isLoad) rdata_m <= rdNext;
  end

  // A store arriving while a byte is still pending is dropped; software polls STATUS.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= '0;
    end else if (uart_tx_valid) begin
      if (uart_tx_ready) uart_tx_valid <= 1'b0;
    end else if (isStore && (sel == IO_TX_DATA)) begin
      uart_tx_valid <= 1'b1;
      uart_tx_data  <= wdata_x[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (isStore && (sel == IO_CNT_RST))) begin
      cycles <= '0;
      instrs <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (instr_valid) instrs <= instrs + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips150_io_ctrl.sv
// Directed testbench for mips150_io_ctrl; FIFO-specific steps run when
// MIPS150_IO_RX_FIFO_EN is defined, single-entry steps otherwise.
module tb_mips150_io_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] addr_x;
  logic [31:0] wdata_x;
  logic [3:0]  store_mask_io;
  logic        load_io_x;
  logic        instr_valid;
  logic [31:0] rdata_m;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;

  int nCmp = 0;
  int nBad = 0;

  localparam logic [31:0] A_STATUS  = 32'h8000_0000;
  localparam logic [31:0] A_RX      = 32'h8000_0004;
  localparam logic [31:0] A_TX      = 32'h8000_0008;
  localparam logic [31:0] A_CYCLES  = 32'h8000_0010;
  localparam logic [31:0] A_INSTRS  = 32'h8000_0014;
  localparam logic [31:0] A_CNT_RST = 32'h8000_0018;

  mips150_io_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .addr_x       (addr_x),
    .wdata_x      (wdata_x),
    .store_mask_io(store_mask_io),
    .load_io_x    (load_io_x),
    .instr_valid  (instr_valid),
    .rdata_m      (rdata_m),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready),
    .uart_tx_data (uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge, outputs are read there too
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ioLoad(input logic [31:0] a);
    addr_x    = a;
    load_io_x = 1'b1;
    tick();
    load_io_x = 1'b0;
  endtask

  task automatic ioStore(input logic [31:0] a, input logic [31:0] d);
    addr_x        = a;
    wdata_x       = d;
    store_mask_io = 4'hF;
    tick();
    store_mask_io = 4'h0;
  endtask

  task automatic rxPush(input logic [7:0] d);
    uart_rx_data  = d;
    uart_rx_valid = 1'b1;
    tick();
    uart_rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    addr_x = '0;
    wdata_x = '0;
    store_mask_io = '0;
    load_io_x = 1'b0;
    instr_valid = 1'b0;
    uart_rx_data = '0;
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b0;

    // 1) reset state and STATUS
    chk("rst_rdata", rdata_m, 32'h0);
    chk("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
    chk("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    ioLoad(A_STATUS);
    chk("status_idle", rdata_m, 32'h1);
    ioLoad(32'h0000_0004);
    chk("nonhit_holds", rdata_m, 32'h1);
    ioLoad(32'h8000_000C);
    chk("unmapped_zero", rdata_m, 32'h0);
    ioLoad(32'h8ABC_0F00);
    chk("status_alias", rdata_m, 32'h1);

    // 2) TX handshake with a busy UART, second store dropped
    ioStore(A_TX, 32'hFFFF_FF41);
    chk("tx_valid_c1", {31'b0, uart_tx_valid}, 32'h1);
    chk("tx_data_c1", {24'b0, uart_tx_data}, 32'h41);
    ioLoad(A_STATUS);
    chk("status_busy", rdata_m, 32'h0);
    chk("tx_valid_c2", {31'b0, uart_tx_valid}, 32'h1);
    ioStore(A_TX, 32'h42);
    chk("tx_valid_c3", {31'b0, uart_tx_valid}, 32'h1);
    chk("tx_data_drop", {24'b0, uart_tx_data}, 32'h41);
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    chk("tx_valid_done", {31'b0, uart_tx_valid}, 32'h0);
    tick();
    chk("tx_no_resend", {31'b0, uart_tx_valid}, 32'h0);
    ioLoad(A_STATUS);
    chk("status_tx_free", rdata_m, 32'h1);

    // 3) single RX byte
    rxPush(8'h5A);
    ioLoad(A_STATUS);
    chk("status_rx_avail", rdata_m, 32'h3);
    ioLoad(A_RX);
    chk("rx_5a", rdata_m, 32'h5A);
    tick();
    chk("rdata_hold", rdata_m, 32'h5A);
    ioLoad(A_RX);
    chk("rx_empty_zero", rdata_m, 32'h0);
    chk("rx_ready_again", {31'b0, uart_rx_ready}, 32'h1);

`ifdef MIPS150_IO_RX_FIFO_EN
    // 4) FIFO fill, stall, concurrent push+pop, in-order drain
    rxPush(8'h01);
    rxPush(8'h02);
    rxPush(8'h03);
    chk("fifo_ready_3", {31'b0, uart_rx_ready}, 32'h1);
    rxPush(8'h04);
    chk("fifo_full", {31'b0, uart_rx_ready}, 32'h0);
    rxPush(8'h05);
    chk("fifo_still_full", {31'b0, uart_rx_ready}, 32'h0);
    ioLoad(A_RX);
    chk("fifo_pop1", rdata_m, 32'h01);
    chk("fifo_not_full", {31'b0, uart_rx_ready}, 32'h1);
    uart_rx_data  = 8'h05;
    uart_rx_valid = 1'b1;
    ioLoad(A_RX);
    uart_rx_valid = 1'b0;
    chk("fifo_pop2_push", rdata_m, 32'h02);
    chk("fifo_count_kept", {31'b0, uart_rx_ready}, 32'h1);
    ioLoad(A_RX);
    chk("fifo_pop3", rdata_m, 32'h03);
    ioLoad(A_RX);
    chk("fifo_pop4", rdata_m, 32'h04);
    ioLoad(A_RX);
    chk("fifo_pop5", rdata_m, 32'h05);
    ioLoad(A_RX);
    chk("fifo_drained", rdata_m, 32'h0);
`else
    // 4) single entry: a second byte waits until the first is read
    rxPush(8'h11);
    chk("hold_full", {31'b0, uart_rx_ready}, 32'h0);
    rxPush(8'h22);
    ioLoad(A_RX);
    chk("hold_first", rdata_m, 32'h11);
    ioLoad(A_RX);
    chk("hold_drained", rdata_m, 32'h0);
`endif

    // 5) counters
    ioStore(A_CNT_RST, 32'h1234_5678);
    ioLoad(A_CYCLES);
    chk("cycles_cleared", rdata_m, 32'h0);
    ioLoad(A_INSTRS);
    chk("instrs_cleared", rdata_m, 32'h0);
    instr_valid = 1'b1;
    tick();
    tick();
    tick();
    instr_valid = 1'b0;
    ioLoad(A_INSTRS);
    chk("instrs_three", rdata_m, 32'h3);
    ioLoad(A_CYCLES);
    chk("cycles_six", rdata_m, 32'h5 + 32'h1);
    dut.cycles = 32'hFFFF_FFFE;
    tick();
    ioLoad(A_CYCLES);
    chk("cycles_max", rdata_m, 32'hFFFF_FFFF);
    ioLoad(A_CYCLES);
    chk("cycles_wrap", rdata_m, 32'h0);

    // 6) reset while TX pending and RX holding
    addr_x        = A_TX;
    wdata_x       = 32'h77;
    store_mask_io = 4'hF;
    uart_rx_data  = 8'h33;
    uart_rx_valid = 1'b1;
    tick();
    store_mask_io = 4'h0;
    uart_rx_valid = 1'b0;
    ioLoad(A_STATUS);
    chk("status_both", rdata_m, 32'h2);
    chk("tx_data_77", {24'b0, uart_tx_data}, 32'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_rdata", rdata_m, 32'h0);
    chk("rst2_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    chk("rst2_tx_data", {24'b0, uart_tx_data}, 32'h0);
    chk("rst2_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    ioLoad(A_RX);
    chk("rst2_rx_empty", rdata_m, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
